// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a binary producer and the sequential BCD converter.
// Master drives in_valid/din; the converter (slave) returns in_ready and the held BCD result.
interface bin2bcd_seq_if #(
   parameter int IN_W       = 32,
   parameter int OUT_DIGITS = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [IN_W-1:0]         din;
   logic                    out_valid;
   logic [4*OUT_DIGITS-1:0] dout;
   logic                    neg;
   logic                    ovf;

   modport master (
      output in_valid, din,
      input  in_ready, out_valid, dout, neg, ovf
   );

   modport slave (
      input  in_valid, din,
      output in_ready, out_valid, dout, neg, ovf
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one bit per cycle; result IN_W+1 edges after acceptance.
// in_ready is high only when idle; in_valid while busy is dropped, and dout/neg/ovf hold until the next result.
module bin2bcd_seq #(
   parameter int IN_W       = 32,
   parameter int INT_DIGITS = 10,
   parameter int OUT_DIGITS = 8,
   parameter bit SIGNED     = 1'b0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   bin2bcd_seq_if.slave bus
);
   localparam int BCD_W = 4 * INT_DIGITS;
   localparam int OUT_W = 4 * OUT_DIGITS;
   localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [IN_W-1:0]  r_shreg;
   logic [BCD_W-1:0] r_bcd;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sign;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [OUT_W-1:0] r_dout;
   logic             r_neg;
   logic             r_ovf;

   logic [BCD_W-1:0] w_bcd_adj;
   logic [IN_W-1:0]  w_mag;
   logic             w_sign;
   logic             w_upper_nz;

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int d = 0; d < INT_DIGITS; d++) begin
         if (r_bcd[4*d +: 4] >= 4'd5) begin
            w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
         end
      end
   end

   // The most negative input negates to itself, which read unsigned is exactly its magnitude.
   always_comb begin
      w_sign = SIGNED && bus.din[IN_W-1];
      w_mag  = w_sign ? (~bus.din + IN_W'(1)) : bus.din;
   end

   always_comb begin
      w_upper_nz = 1'b0;
      for (int d = OUT_DIGITS; d < INT_DIGITS; d++) begin
         w_upper_nz = w_upper_nz | (|r_bcd[4*d +: 4]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_shreg     <= '0;
         r_bcd       <= '0;
         r_cnt       <= '0;
         r_sign      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_dout      <= '0;
         r_neg       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_shreg    <= w_mag;
                  r_sign     <= w_sign;
                  r_bcd      <= '0;
                  r_cnt      <= CNT_W'(IN_W - 1);
                  r_in_ready <= 1'b0;
                  r_state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // Top bit of the adjusted accumulator is always zero, so the cast drops nothing.
               r_bcd   <= BCD_W'({w_bcd_adj, r_shreg[IN_W-1]});
               r_shreg <= {r_shreg[IN_W-2:0], 1'b0};
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               r_out_valid <= 1'b1;
               r_ovf       <= w_upper_nz;
               r_neg       <= r_sign;
               r_dout      <= w_upper_nz ? {OUT_DIGITS{4'hE}} : r_bcd[OUT_W-1:0];
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_in_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.dout      = r_dout;
   assign bus.neg       = r_neg;
   assign bus.ovf       = r_ovf;
endmodule
